// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO writes.
// Latency WIDTH+1 cycles from accepted start to done; start and MT writes are ignored while busy.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] WriteData,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_q, r_neg_r, r_bz;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_done, r_dz;

    logic               w_accept, w_last;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_madd, w_rsh, w_diff;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Signed ops run on magnitudes; signs are reapplied at FINISH.
    assign w_a_neg = op[0] & A[WIDTH-1];
    assign w_b_neg = op[0] & B[WIDTH-1];
    assign w_abs_a = w_a_neg ? -A : A;
    assign w_abs_b = w_b_neg ? -B : B;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign w_rsh      = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_rsh - {1'b0, r_b};
    assign w_div_next = w_diff[WIDTH] ? {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start)  w_next = S_RUN;
            S_RUN:    if (w_last) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_op    <= 2'b00;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= WriteData;
                    if (lo_we) r_lo <= WriteData;
                    if (w_accept) begin
                        r_op    <= op;
                        // Divide keeps raw A for the divide-by-zero HI value.
                        r_a     <= op[1] ? A : w_abs_a;
                        r_b     <= w_abs_b;
                        r_acc   <= op[1] ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
                        r_cnt   <= '0;
                        r_dz    <= 1'b0;
                        r_bz    <= (B == '0);
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                    end
                end
                S_RUN: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    if (!r_op[1]) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (r_bz) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                        r_dz <= 1'b1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign HI          = r_hi;
    assign LO          = r_lo;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: reset, arithmetic vectors, ignored start, reset abort, MT writes.
module tb_mips_muldiv_unit;
    logic        CLK = 1'b0;
    logic        RESET, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] A, B, WriteData;
    logic        busy, done, div_by_zero;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_bad = 0;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .WriteData(WriteData),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pulses start for one edge, then scrambles operands to show they are not re-sampled.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0; op = ~o; A = 32'hA5A5_5A5A; B = 32'h0F0F_F0F0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 100);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(); tick();
        n_cmp += 5;
        if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)        begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dz: got %b want 0", div_by_zero); end
        if (HI !== 32'h0)         begin n_bad++; $display("FAIL reset_hi: got %h want 0", HI); end
        if (LO !== 32'h0)         begin n_bad++; $display("FAIL reset_lo: got %h want 0", LO); end
        RESET = 1'b0;
        tick();
    endtask

    // Vectors run back to back: each start is issued in the cycle where the previous done is high.
    task automatic test_arith();
        logic [1:0]  t_op [13] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
        logic [31:0] t_a  [13] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hD, 32'hFFFFFFF9, 32'h7, 32'h80000000,
                                   32'hFFFFFFFF, 32'h6, 32'h80000000, 32'hFFFFFFFF, 32'h10, 32'hFFFFFFF0, 32'h0};
        logic [31:0] t_b  [13] = '{32'hFFFFFFFF, 32'h4, 32'hA, 32'h2, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                   32'hFFFFFFFF, 32'h7, 32'h80000000, 32'h10, 32'h0, 32'h0, 32'h1234};
        logic [31:0] t_hi [13] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFF, 32'h1, 32'h0,
                                   32'h0, 32'h0, 32'h40000000, 32'hF, 32'h10, 32'hFFFFFFF0, 32'h0};
        logic [31:0] t_lo [13] = '{32'h00000001, 32'hFFFFFFF4, 32'h1, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000,
                                   32'h1, 32'h2A, 32'h0, 32'h0FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        logic        t_dz [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int n;
        for (int i = 0; i < 13; i++) begin
            launch(t_op[i], t_a[i], t_b[i]);
            n_cmp += 2;
            if (busy !== 1'b1)        begin n_bad++; $display("FAIL arith_busy[%0d]: got %b want 1", i, busy); end
            if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL arith_dz_clear[%0d]: got %b want 0", i, div_by_zero); end
            wait_done(n);
            n_cmp += 5;
            if (n != 33)                 begin n_bad++; $display("FAIL arith_latency[%0d]: got %0d want 33", i, n); end
            if (busy !== 1'b0)           begin n_bad++; $display("FAIL arith_busy_done[%0d]: got %b want 0", i, busy); end
            if (HI !== t_hi[i])          begin n_bad++; $display("FAIL arith_hi[%0d]: got %h want %h", i, HI, t_hi[i]); end
            if (LO !== t_lo[i])          begin n_bad++; $display("FAIL arith_lo[%0d]: got %h want %h", i, LO, t_lo[i]); end
            if (div_by_zero !== t_dz[i]) begin n_bad++; $display("FAIL arith_dz[%0d]: got %b want %b", i, div_by_zero, t_dz[i]); end
        end
        tick();
        n_cmp += 2;
        if (done !== 1'b0)        begin n_bad++; $display("FAIL arith_done_pulse: got %b want 0", done); end
        if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL arith_dz_final: got %b want 0", div_by_zero); end
    endtask

    task automatic test_start_ignored();
        int n;
        int seen;
        launch(2'd0, 32'd6, 32'd7);
        repeat (9) tick();
        op = 2'd2; A = 32'd1; B = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        n_cmp += 3;
        if (n + 10 != 33) begin n_bad++; $display("FAIL ignore_latency: got %0d want 33", n + 10); end
        if (LO !== 32'h2A) begin n_bad++; $display("FAIL ignore_lo: got %h want 0000002a", LO); end
        if (HI !== 32'h0)  begin n_bad++; $display("FAIL ignore_hi: got %h want 0", HI); end
        tick();
        n_cmp += 1;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_queue: got busy %b want 0", busy); end

        launch(2'd0, 32'd6, 32'd7);
        repeat (19) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        n_cmp += 4;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", done); end
        if (HI !== 32'h0)  begin n_bad++; $display("FAIL abort_hi: got %h want 0", HI); end
        if (LO !== 32'h0)  begin n_bad++; $display("FAIL abort_lo: got %h want 0", LO); end
        seen = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen++;
        end
        n_cmp += 1;
        if (seen != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    endtask

    task automatic test_mt();
        int n;
        hi_we = 1'b1; WriteData = 32'h12345678;
        tick();
        hi_we = 1'b0;
        n_cmp += 1;
        if (HI !== 32'h12345678) begin n_bad++; $display("FAIL mthi_idle: got %h want 12345678", HI); end
        lo_we = 1'b1; WriteData = 32'h0BADF00D;
        tick();
        lo_we = 1'b0;
        n_cmp += 1;
        if (LO !== 32'h0BADF00D) begin n_bad++; $display("FAIL mtlo_idle: got %h want 0badf00d", LO); end

        hi_we = 1'b1; WriteData = 32'hCAFEBABE;
        launch(2'd0, 32'd2, 32'd3);
        hi_we = 1'b0;
        n_cmp += 1;
        if (HI !== 32'hCAFEBABE) begin n_bad++; $display("FAIL mthi_with_start: got %h want cafebabe", HI); end
        repeat (3) tick();
        lo_we = 1'b1; hi_we = 1'b1; WriteData = 32'hFFFF0000;
        repeat (5) tick();
        n_cmp += 2;
        if (LO !== 32'h0BADF00D) begin n_bad++; $display("FAIL mtlo_busy: got %h want 0badf00d", LO); end
        if (HI !== 32'hCAFEBABE) begin n_bad++; $display("FAIL mthi_busy: got %h want cafebabe", HI); end
        lo_we = 1'b0; hi_we = 1'b0;
        wait_done(n);
        n_cmp += 3;
        if (n + 8 != 33)  begin n_bad++; $display("FAIL mt_latency: got %0d want 33", n + 8); end
        if (HI !== 32'h0) begin n_bad++; $display("FAIL mt_finish_hi: got %h want 0", HI); end
        if (LO !== 32'h6) begin n_bad++; $display("FAIL mt_finish_lo: got %h want 6", LO); end
    endtask

    initial begin
        RESET = 1'b1; start = 1'b0; op = 2'd0; A = '0; B = '0;
        hi_we = 1'b0; lo_we = 1'b0; WriteData = '0;
        test_reset();
        test_arith();
        test_start_ignored();
        test_mt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
